// File: rtl/bsh_norm_32.sv
// rtl/bsh_norm_32.sv - three-stage pipelined normalizer (leading/trailing zero count plus shift)
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake carrying data_in and dir
//   data_in, dir         word to normalize; dir=0 left (clz), dir=1 right (ctz)
//   out_valid/out_ready  output handshake
//   data_out, sh         normalized word and the shift amount applied
//   zero, out_dir        data_in was all zeros; dir carried with the result
//   zcnt, zcnt_clr       zero-result transfer counter and its clear (only with BSH_NORM_ZCNT_EN)
//
// Optional feature macro: BSH_NORM_ZCNT_EN

module bsh_norm_32 #(
    parameter  int WIDTH = 32,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BSH_NORM_ZCNT_EN
    input  logic             zcnt_clr,
    output logic [15:0]      zcnt,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [SH_W-1:0]  sh,
    output logic             zero,
    output logic             out_dir
);

    // S1 capture
    logic             v1;
    logic [WIDTH-1:0] d1;
    logic             dir1;
    // S2 count
    logic             v2;
    logic [WIDTH-1:0] d2;
    logic             dir2;
    logic [SH_W-1:0]  cnt2;
    logic             zero2;

    logic adv1, adv2, adv3;

    // Back-to-front advance chain; in_ready depends on out_ready only, never on in_valid.
    assign adv3     = !out_valid || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // Trailing-zero counting is done as leading-zero counting on the bit-reversed word,
    // so a single tree serves both directions.
    logic [WIDTH-1:0] scan;
    logic [WIDTH-1:0] probe;
    logic [SH_W-1:0]  cnt1;
    logic             zero1;

    always_comb begin
        scan = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scan[i] = dir1 ? d1[WIDTH-1-i] : d1[i];
        end
        // Binary-search normalization: at each level, if the top 2^k bits are all zero,
        // that bit of the count is set and the window slides up by 2^k.
        probe = scan;
        cnt1  = '0;
        for (int k = SH_W - 1; k >= 0; k--) begin
            if ((probe >> (WIDTH - (1 << k))) == '0) begin
                cnt1[k] = 1'b1;
                probe   = probe << (1 << k);
            end
        end
        zero1 = (d1 == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            d1        <= '0;
            dir1      <= 1'b0;
            v2        <= 1'b0;
            d2        <= '0;
            dir2      <= 1'b0;
            cnt2      <= '0;
            zero2     <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            sh        <= '0;
            zero      <= 1'b0;
            out_dir   <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    d1   <= data_in;
                    dir1 <= dir;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    d2    <= d1;
                    dir2  <= dir1;
                    // The tree saturates to all ones on a zero word; report 0 instead.
                    cnt2  <= zero1 ? '0 : cnt1;
                    zero2 <= zero1;
                end
            end
            if (adv3) begin
                out_valid <= v2;
                if (v2) begin
                    data_out <= dir2 ? (d2 >> cnt2) : (d2 << cnt2);
                    sh       <= cnt2;
                    zero     <= zero2;
                    out_dir  <= dir2;
                end
            end
        end
    end

`ifdef BSH_NORM_ZCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zcnt <= '0;
        end else if (zcnt_clr) begin
            zcnt <= '0;
        end else if (out_valid && out_ready && zero && (zcnt != 16'hFFFF)) begin
            zcnt <= zcnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bsh_norm_32.sv
// tb/tb_bsh_norm_32.sv - randomized and directed self-checking bench for bsh_norm_32

module tb_bsh_norm_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic        dir = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic [4:0]  sh;
    logic        zero;
    logic        out_dir;
`ifdef BSH_NORM_ZCNT_EN
    logic        zcnt_clr = 1'b0;
    logic [15:0] zcnt;
    int          zcnt_exp = 0;
`endif

    always #5 clk = ~clk;

    bsh_norm_32 dut (
        .clk      (clk),
        .rst      (rst),
`ifdef BSH_NORM_ZCNT_EN
        .zcnt_clr (zcnt_clr),
        .zcnt     (zcnt),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .dir      (dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .sh       (sh),
        .zero     (zero),
        .out_dir  (out_dir)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: shift one bit at a time until the target end bit is set.
    task automatic model(input logic [31:0] d, input logic dr,
                         output logic [31:0] o, output logic [4:0] s, output logic z);
        int n = 0;
        o = d;
        z = (d == 0);
        if (!z) begin
            if (!dr) while (o[31] == 1'b0) begin o = o << 1; n++; end
            else     while (o[0]  == 1'b0) begin o = o >> 1; n++; end
        end
        s = n[4:0];
    endtask

    logic [31:0] q_in[$];
    logic        q_dir[$];
    int          n_acc = 0;
    logic        hold_prev = 1'b0;
    logic [38:0] prev_out;
    logic        saw_stall = 1'b0;

    // One cycle: inputs are already set (at negedge); evaluate the upcoming edge's transfers.
    task automatic step();
        logic [31:0] ein, eo;
        logic        edr, ez;
        logic [4:0]  es;
        #1;
        if (hold_prev) check("stable", {data_out, sh, zero, out_dir}, {prev_out, 1'b1} >> 1);
        hold_prev = out_valid && !out_ready;
        prev_out  = {data_out, sh, zero, out_dir};
        if (in_valid && !in_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) begin
            if (q_in.size() == 0) begin
                check("spurious", {63'd0, out_valid}, 64'd0);
            end else begin
                ein = q_in.pop_front();
                edr = q_dir.pop_front();
                model(ein, edr, eo, es, ez);
                check("data_out", {32'd0, data_out}, {32'd0, eo});
                check("sh", {59'd0, sh}, {59'd0, es});
                check("zero", {63'd0, zero}, {63'd0, ez});
                check("out_dir", {63'd0, out_dir}, {63'd0, edr});
                if (ein != 0)
                    check("roundtrip", {32'd0, (out_dir ? (data_out << sh) : (data_out >> sh))}, {32'd0, ein});
`ifdef BSH_NORM_ZCNT_EN
                if (ez && zcnt_exp < 65535) zcnt_exp++;
`endif
            end
        end
        if (in_valid && in_ready) begin
            q_in.push_back(data_in);
            q_dir.push_back(dir);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 30;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q_in.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        check("drain", {32'd0, q_in.size()}, 64'd0);
    endtask

    logic [31:0] vec_d[7] = '{32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000,
                              32'h0, 32'h0, 32'h0000_0001};
    logic        vec_r[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int target, budget;
        void'($urandom(32'd20240611));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", {25'd0, data_out, sh, zero, out_dir}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // Latency: accepted at E, visible after E+2
        in_valid = 1'b1; data_in = 32'h0001_0000; dir = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_e0", {63'd0, out_valid}, 64'd0);
        step();
        check("lat_e1", {63'd0, out_valid}, 64'd0);
        step();
        check("lat_e2_valid", {63'd0, out_valid}, 64'd1);
        check("lat_e2_sh", {59'd0, sh}, 64'd15);
        check("lat_e2_data", {32'd0, data_out}, 64'h8000_0000);
        drain();

        // Directed vectors streamed back to back
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; data_in = vec_d[i]; dir = vec_r[i];
            step();
        end
        drain();

        // Backpressure: 5 words, out_ready low for 4 cycles mid-stream
        saw_stall = 1'b0;
        target = n_acc + 5;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 2 && c < 6);
            in_valid  = (n_acc < target);
            data_in   = $urandom;
            dir       = 1'($urandom_range(0, 1));
            step();
        end
        check("bp_stall_seen", {63'd0, saw_stall}, 64'd1);
        drain();

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'h0000_0F00 << i; dir = 1'b0;
            step();
        end
        in_valid = 1'b0;
        check("rst_pre_valid", {63'd0, out_valid}, 64'd1);
        #3 rst = 1'b1;
        #1 check("rst_async", {63'd0, out_valid}, 64'd0);
        q_in.delete(); q_dir.delete();
        hold_prev = 1'b0;
`ifdef BSH_NORM_ZCNT_EN
        zcnt_exp = 0;
`endif
        #7 rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b1; data_in = 32'h0000_0400; dir = 1'b1;
        step();
        drain();

        // Randomized stream
        target = n_acc + 200;
        budget = 3000;
        while (n_acc < target && budget > 0) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            dir       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       data_in = 32'h0;
                1:       data_in = 32'h1 << $urandom_range(0, 31);
                2:       data_in = 32'hFFFF_FFFF;
                3, 4:    data_in = $urandom >> $urandom_range(0, 31);
                5, 6:    data_in = $urandom << $urandom_range(0, 31);
                default: data_in = $urandom;
            endcase
            step();
            budget--;
        end
        check("rand_accept_budget", {63'd0, (n_acc >= target)}, 64'd1);
        drain();

`ifdef BSH_NORM_ZCNT_EN
        check("zcnt", {48'd0, zcnt}, 64'(zcnt_exp));
        zcnt_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zcnt_clr = 1'b0;
        check("zcnt_clr", {48'd0, zcnt}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
